memory_access_cycle: RTL and testbench

- MEM pipeline stage of the 5-stage RV32I core. Sits directly after the execute stage and consumes the EXE pipeline register outputs.
- Runs a ready-handshake bus transaction for loads and stores: byte-lane steering, load sign/zero extension, wait-state stall generation and a timeout.
- Captures the MEM/WB pipeline register that feeds writeback and the forwarding paths.

---
 rtl/mem_pkg.sv | 17 +
 rtl/memory_access_cycle_align.sv | 72 +++++++
 rtl/memory_access_cycle.sv | 162 ++++++++++++++++
 tb/tb_memory_access_cycle.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared constants and types for the MEM pipeline stage of the RV32I core.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [2:0] RFWD_SEL_LOAD = 3'b001;

    typedef enum logic {
        IDLE,
        WAIT
    } mem_state_t;

endpackage

// File: rtl/memory_access_cycle_align.sv
// Byte-lane steering for RV32I loads/stores: byte enables, write-data
// replication, legality/alignment checks and load extraction/extension.
module load_store_align
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic        is_store,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic [3:0]  byte_en,
    output logic [31:0] write_data,
    output logic [31:0] load_data,
    output logic        illegal,
    output logic        misaligned
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    always_comb begin
        case (funct3)
            F3_B, F3_H, F3_W: illegal = 1'b0;
            F3_BU, F3_HU:     illegal = is_store;
            default:          illegal = 1'b1;
        endcase
    end

    // Size is encoded in funct3[1:0]; the unsigned loads share lanes with the signed ones.
    always_comb begin
        byte_en    = '0;
        write_data = '0;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                byte_en    = 4'b0001 << offset;
                write_data = {4{store_data[7:0]}};
            end
            2'b01: begin
                byte_en    = offset[1] ? 4'b1100 : 4'b0011;
                write_data = {2{store_data[15:0]}};
                misaligned = offset[0];
            end
            default: begin
                byte_en    = 4'b1111;
                write_data = store_data;
                misaligned = (offset != 2'b00);
            end
        endcase
    end

    always_comb begin
        case (offset)
            2'd0:    lane_byte = read_data[7:0];
            2'd1:    lane_byte = read_data[15:8];
            2'd2:    lane_byte = read_data[23:16];
            default: lane_byte = read_data[31:24];
        endcase
        lane_half = offset[1] ? read_data[31:16] : read_data[15:0];
    end

    always_comb begin
        case (funct3)
            F3_B:    load_data = {{24{lane_byte[7]}}, lane_byte};
            F3_BU:   load_data = {24'b0, lane_byte};
            F3_H:    load_data = {{16{lane_half[15]}}, lane_half};
            F3_HU:   load_data = {16'b0, lane_half};
            default: load_data = read_data;
        endcase
    end

endmodule

// File: rtl/memory_access_cycle.sv
// MEM stage of the RV32I pipeline: ready-handshake load/store bus access with
// wait-state stalling, timeout abort and the MEM/WB pipeline register.
module memory_access_cycle
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        regFileWe_EXE,
    input  logic [2:0]  RFWDSrcMuxSel_EXE,
    input  logic        busWe_EXE,
    input  logic [31:0] instrCode_EXE,
    input  logic [31:0] aluResult_EXE,
    input  logic [31:0] RFData2_EXE,
    input  logic [31:0] immExt_EXE,
    input  logic [31:0] PC_Imm_AdderResult_EXE,
    input  logic [31:0] PC_4_AdderResult_EXE,
    output logic        busReq,
    output logic        busWe,
    output logic [31:0] busAddr,
    output logic [3:0]  busBE,
    output logic [31:0] busWData,
    input  logic        busReady,
    input  logic [31:0] busRData,
    output logic        stall_MEM,
    output logic        accessFault,
    output logic        regFileWe_MEM,
    output logic [2:0]  RFWDSrcMuxSel_MEM,
    output logic [31:0] instrCode_MEM,
    output logic [31:0] aluResult_MEM,
    output logic [31:0] loadData_MEM,
    output logic [31:0] immExt_MEM,
    output logic [31:0] PC_Imm_AdderResult_MEM,
    output logic [31:0] PC_4_AdderResult_MEM
);

    mem_state_t       state;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      hold_addr;
    logic [31:0]      hold_wdata;
    logic [2:0]       hold_funct3;
    logic             hold_we;

    logic        in_wait;
    logic        access;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [2:0]  cur_funct3;
    logic        cur_we;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] lane_load;
    logic        illegal;
    logic        misaligned;
    logic        req_ok;
    logic        timeout;
    logic        bus_active;
    logic        complete;
    logic        fault;

    assign in_wait = (state == WAIT);
    assign access  = busWe_EXE || (RFWDSrcMuxSel_EXE == RFWD_SEL_LOAD);

    // Once waiting, every bus field comes from the hold registers so the
    // request stays stable regardless of what the EXE register presents.
    assign cur_addr   = in_wait ? hold_addr   : aluResult_EXE;
    assign cur_wdata  = in_wait ? hold_wdata  : RFData2_EXE;
    assign cur_funct3 = in_wait ? hold_funct3 : instrCode_EXE[14:12];
    assign cur_we     = in_wait ? hold_we     : busWe_EXE;

    load_store_align u_align (
        .funct3     (cur_funct3),
        .offset     (cur_addr[1:0]),
        .is_store   (cur_we),
        .store_data (cur_wdata),
        .read_data  (busRData),
        .byte_en    (lane_be),
        .write_data (lane_wdata),
        .load_data  (lane_load),
        .illegal    (illegal),
        .misaligned (misaligned)
    );

    assign req_ok     = access && !illegal && !misaligned;
    assign timeout    = in_wait && (wait_cnt == CNT_W'(TIMEOUT_CYCLES));
    assign bus_active = !reset && (in_wait || req_ok);
    assign complete   = bus_active && busReady;
    assign fault      = !reset && ((!in_wait && access && (illegal || misaligned))
                                   || (timeout && !busReady));

    assign stall_MEM   = !reset && ((!in_wait && req_ok && !busReady)
                                    || (in_wait && !busReady && !timeout));
    assign accessFault = fault;

    assign busReq   = bus_active;
    assign busWe    = bus_active && cur_we;
    assign busAddr  = bus_active ? {cur_addr[31:2], 2'b00} : '0;
    assign busBE    = bus_active ? lane_be : '0;
    assign busWData = (bus_active && cur_we) ? lane_wdata : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            hold_addr   <= '0;
            hold_wdata  <= '0;
            hold_funct3 <= '0;
            hold_we     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_ok && !busReady) begin
                        state       <= WAIT;
                        wait_cnt    <= CNT_W'(1);
                        hold_addr   <= aluResult_EXE;
                        hold_wdata  <= RFData2_EXE;
                        hold_funct3 <= instrCode_EXE[14:12];
                        hold_we     <= busWe_EXE;
                    end
                end
                WAIT: begin
                    if (busReady || timeout) begin
                        state    <= IDLE;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regFileWe_MEM          <= 1'b0;
            RFWDSrcMuxSel_MEM      <= '0;
            instrCode_MEM          <= '0;
            aluResult_MEM          <= '0;
            loadData_MEM           <= '0;
            immExt_MEM             <= '0;
            PC_Imm_AdderResult_MEM <= '0;
            PC_4_AdderResult_MEM   <= '0;
        end else if (stall_MEM) begin
            regFileWe_MEM     <= 1'b0;
            RFWDSrcMuxSel_MEM <= '0;
            instrCode_MEM     <= '0;
        end else begin
            regFileWe_MEM          <= regFileWe_EXE && !fault;
            RFWDSrcMuxSel_MEM      <= RFWDSrcMuxSel_EXE;
            instrCode_MEM          <= instrCode_EXE;
            aluResult_MEM          <= aluResult_EXE;
            loadData_MEM           <= (complete && !cur_we) ? lane_load : '0;
            immExt_MEM             <= immExt_EXE;
            PC_Imm_AdderResult_MEM <= PC_Imm_AdderResult_EXE;
            PC_4_AdderResult_MEM   <= PC_4_AdderResult_EXE;
        end
    end

endmodule

// File: tb/tb_memory_access_cycle.sv
// Randomized self-checking bench for memory_access_cycle against a byte-level
// behavioural model of RV32I load/store lane rules and wait/timeout timing.
module tb_memory_access_cycle;
    import mem_pkg::*;

    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        regFileWe_EXE;
    logic [2:0]  RFWDSrcMuxSel_EXE;
    logic        busWe_EXE;
    logic [31:0] instrCode_EXE, aluResult_EXE, RFData2_EXE;
    logic [31:0] immExt_EXE, PC_Imm_AdderResult_EXE, PC_4_AdderResult_EXE;
    logic        busReq, busWe;
    logic [31:0] busAddr, busWData, busRData;
    logic [3:0]  busBE;
    logic        busReady, stall_MEM, accessFault;
    logic        regFileWe_MEM;
    logic [2:0]  RFWDSrcMuxSel_MEM;
    logic [31:0] instrCode_MEM, aluResult_MEM, loadData_MEM, immExt_MEM;
    logic [31:0] PC_Imm_AdderResult_MEM, PC_4_AdderResult_MEM;

    int tests = 0;
    int fails = 0;

    memory_access_cycle #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .regFileWe_EXE(regFileWe_EXE), .RFWDSrcMuxSel_EXE(RFWDSrcMuxSel_EXE),
        .busWe_EXE(busWe_EXE), .instrCode_EXE(instrCode_EXE),
        .aluResult_EXE(aluResult_EXE), .RFData2_EXE(RFData2_EXE),
        .immExt_EXE(immExt_EXE), .PC_Imm_AdderResult_EXE(PC_Imm_AdderResult_EXE),
        .PC_4_AdderResult_EXE(PC_4_AdderResult_EXE),
        .busReq(busReq), .busWe(busWe), .busAddr(busAddr), .busBE(busBE),
        .busWData(busWData), .busReady(busReady), .busRData(busRData),
        .stall_MEM(stall_MEM), .accessFault(accessFault),
        .regFileWe_MEM(regFileWe_MEM), .RFWDSrcMuxSel_MEM(RFWDSrcMuxSel_MEM),
        .instrCode_MEM(instrCode_MEM), .aluResult_MEM(aluResult_MEM),
        .loadData_MEM(loadData_MEM), .immExt_MEM(immExt_MEM),
        .PC_Imm_AdderResult_MEM(PC_Imm_AdderResult_MEM),
        .PC_4_AdderResult_MEM(PC_4_AdderResult_MEM)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit legal(input bit store, input logic [2:0] f3);
        if (store) return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
        return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    endfunction

    function automatic bit aligned(input logic [2:0] f3, input logic [31:0] a);
        return (a % size_of(f3)) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = size_of(f3);
        return 4'(((1 << sz) - 1) << a[1:0]);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        int sz = size_of(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        int sz = size_of(f3);
        longint v;
        v = longint'(rd >> (8 * a[1:0])) & ((64'd1 << (8 * sz)) - 1);
        if (!f3[2] && sz < 4 && v >= longint'(64'd1 << (8 * sz - 1)))
            v = v - longint'(64'd1 << (8 * sz));
        return v[31:0];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_exe(input logic rfwe, input logic [2:0] sel, input logic we,
                             input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rs2);
        regFileWe_EXE          = rfwe;
        RFWDSrcMuxSel_EXE      = sel;
        busWe_EXE              = we;
        instrCode_EXE          = $urandom;
        instrCode_EXE[14:12]   = f3;
        aluResult_EXE          = a;
        RFData2_EXE            = rs2;
        immExt_EXE             = $urandom;
        PC_Imm_AdderResult_EXE = $urandom;
        PC_4_AdderResult_EXE   = $urandom;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        busReady = 1'b1;
        busRData = '1;
        drive_exe(1'b1, RFWD_SEL_LOAD, 1'b0, F3_W, 32'h40, 32'h0);
        repeat (2) tick();
        #3;
        tests++;
        if ({busReq, busWe, stall_MEM, accessFault} !== 4'b0) begin
            fails++; $display("FAIL reset_ctl: got %b expected 0000", {busReq, busWe, stall_MEM, accessFault});
        end
        tests++;
        if ({busAddr, busBE, busWData} !== 68'h0) begin
            fails++; $display("FAIL reset_bus: got %h expected 0", {busAddr, busBE, busWData});
        end
        tests++;
        if ({regFileWe_MEM, RFWDSrcMuxSel_MEM, instrCode_MEM, aluResult_MEM, loadData_MEM} !== 100'h0) begin
            fails++; $display("FAIL reset_memwb: got %h expected 0",
                {regFileWe_MEM, RFWDSrcMuxSel_MEM, instrCode_MEM, aluResult_MEM, loadData_MEM});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_alu();
        logic [2:0]  sel;
        logic [31:0] a, imm, pc4;
        logic        rfwe;
        for (int i = 0; i < 8; i++) begin
            do sel = 3'($urandom_range(0, 7)); while (sel == RFWD_SEL_LOAD);
            a = (i == 0) ? 32'h55 : $urandom;
            rfwe = 1'($urandom_range(0, 1));
            drive_exe(rfwe, sel, 1'b0, 3'($urandom_range(0, 7)), a, $urandom);
            imm = immExt_EXE;
            pc4 = PC_4_AdderResult_EXE;
            busReady = 1'($urandom_range(0, 1));
            #3;
            tests++;
            if ({busReq, stall_MEM, accessFault} !== 3'b000) begin
                fails++; $display("FAIL alu_ctl: got %b expected 000", {busReq, stall_MEM, accessFault});
            end
            tick();
            tests++;
            if ({regFileWe_MEM, RFWDSrcMuxSel_MEM, aluResult_MEM, loadData_MEM, immExt_MEM, PC_4_AdderResult_MEM}
                !== {rfwe, sel, a, 32'h0, imm, pc4}) begin
                fails++; $display("FAIL alu_memwb: got %b/%h/%h/%h expected %b/%h/%h/0",
                    regFileWe_MEM, RFWDSrcMuxSel_MEM, aluResult_MEM, loadData_MEM, rfwe, sel, a);
            end
        end
    endtask

    task automatic test_store();
        logic [2:0]  f3;
        logic [31:0] a, d;
        for (int i = 0; i < 12; i++) begin
            if (i == 0) begin
                f3 = F3_W; a = 32'h100; d = 32'hDEADBEEF;
            end else if (i == 1) begin
                f3 = F3_H; a = 32'h102; d = 32'h1234ABCD;
            end else begin
                f3 = 3'($urandom_range(0, 2));
                a  = $urandom;
                a  = a & ~32'(size_of(f3) - 1);
                d  = $urandom;
            end
            busReady = 1'b1;
            drive_exe(1'b0, 3'($urandom_range(0, 7)), 1'b1, f3, a, d);
            #3;
            tests++;
            if ({busReq, busWe, stall_MEM, accessFault} !== 4'b1100) begin
                fails++; $display("FAIL store_ctl: got %b expected 1100", {busReq, busWe, stall_MEM, accessFault});
            end
            tests++;
            if (busAddr !== {a[31:2], 2'b00}) begin
                fails++; $display("FAIL store_addr: got %h expected %h", busAddr, {a[31:2], 2'b00});
            end
            tests++;
            if (busBE !== model_be(f3, a)) begin
                fails++; $display("FAIL store_be: got %b expected %b", busBE, model_be(f3, a));
            end
            tests++;
            if (busWData !== model_wdata(f3, d)) begin
                fails++; $display("FAIL store_wdata: got %h expected %h", busWData, model_wdata(f3, d));
            end
            tick();
            tests++;
            if ({regFileWe_MEM, aluResult_MEM} !== {1'b0, a}) begin
                fails++; $display("FAIL store_memwb: got %b/%h expected 0/%h", regFileWe_MEM, aluResult_MEM, a);
            end
        end
    endtask

    task automatic load_with_waits(input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] rdata, input int waits);
        logic [31:0] instr;
        drive_exe(1'b1, RFWD_SEL_LOAD, 1'b0, f3, a, $urandom);
        instr = instrCode_EXE;
        for (int c = 0; c <= waits; c++) begin
            busReady      = (c == waits);
            busRData      = (c == waits) ? rdata : $urandom;
            aluResult_EXE = (c == 0 || c == waits) ? a : $urandom;
            RFData2_EXE   = $urandom;
            #3;
            tests++;
            if ({busReq, busWe, stall_MEM, accessFault} !== {2'b10, 1'(c < waits), 1'b0}) begin
                fails++; $display("FAIL load_ctl c=%0d: got %b expected %b", c,
                    {busReq, busWe, stall_MEM, accessFault}, {2'b10, 1'(c < waits), 1'b0});
            end
            tests++;
            if ({busAddr, busBE} !== {a[31:2], 2'b00, model_be(f3, a)}) begin
                fails++; $display("FAIL load_bus c=%0d: got %h/%b expected %h/%b", c,
                    busAddr, busBE, {a[31:2], 2'b00}, model_be(f3, a));
            end
            tick();
            if (c < waits) begin
                tests++;
                if ({regFileWe_MEM, RFWDSrcMuxSel_MEM, instrCode_MEM} !== 36'h0) begin
                    fails++; $display("FAIL load_bubble c=%0d: got %b/%h/%h expected 0/0/0", c,
                        regFileWe_MEM, RFWDSrcMuxSel_MEM, instrCode_MEM);
                end
            end else begin
                tests++;
                if (loadData_MEM !== model_load(f3, a, rdata)) begin
                    fails++; $display("FAIL load_data f3=%0d a=%h rd=%h: got %h expected %h",
                        f3, a, rdata, loadData_MEM, model_load(f3, a, rdata));
                end
                tests++;
                if ({regFileWe_MEM, instrCode_MEM} !== {1'b1, instr}) begin
                    fails++; $display("FAIL load_memwb: got %b/%h expected 1/%h", regFileWe_MEM, instrCode_MEM, instr);
                end
            end
        end
    endtask

    task automatic test_load_waits();
        logic [2:0]  f3;
        logic [31:0] a;
        load_with_waits(F3_B,  32'h103, 32'h80000000, 3);
        load_with_waits(F3_BU, 32'h103, 32'h80000000, 3);
        for (int i = 0; i < 14; i++) begin
            case ($urandom_range(0, 4))
                0: f3 = F3_B;
                1: f3 = F3_H;
                2: f3 = F3_W;
                3: f3 = F3_BU;
                default: f3 = F3_HU;
            endcase
            a = $urandom;
            a = a & ~32'(size_of(f3) - 1);
            load_with_waits(f3, a, $urandom, (i < 4) ? 0 : int'($urandom_range(0, 5)));
        end
    endtask

    task automatic test_fault();
        bit          store;
        logic [2:0]  f3;
        logic [31:0] a;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) begin
                store = 1'b0; f3 = F3_H; a = 32'h101;
            end else begin
                do begin
                    store = 1'($urandom_range(0, 1));
                    f3    = 3'($urandom_range(0, 7));
                    a     = $urandom;
                end while (legal(store, f3) && aligned(f3, a));
            end
            drive_exe(1'b1, RFWD_SEL_LOAD, store, f3, a, $urandom);
            busReady = 1'($urandom_range(0, 1));
            busRData = $urandom;
            #3;
            tests++;
            if ({busReq, stall_MEM, accessFault} !== 3'b001) begin
                fails++; $display("FAIL fault_ctl f3=%0d a=%h: got %b expected 001", f3, a,
                    {busReq, stall_MEM, accessFault});
            end
            tick();
            tests++;
            if ({regFileWe_MEM, loadData_MEM, aluResult_MEM} !== {1'b0, 32'h0, a}) begin
                fails++; $display("FAIL fault_memwb: got %b/%h/%h expected 0/0/%h",
                    regFileWe_MEM, loadData_MEM, aluResult_MEM, a);
            end
        end
    endtask

    task automatic test_timeout();
        logic [31:0] a, instr;
        int stalls = 0;
        a = $urandom;
        a = a & ~32'h3;
        drive_exe(1'b1, RFWD_SEL_LOAD, 1'b0, F3_W, a, $urandom);
        instr = instrCode_EXE;
        busReady = 1'b0;
        for (int c = 0; c <= TO; c++) begin
            busRData = $urandom;
            #3;
            if (stall_MEM) stalls++;
            tests++;
            if ({busReq, accessFault} !== {1'b1, 1'(c == TO)}) begin
                fails++; $display("FAIL timeout_ctl c=%0d: got %b expected %b", c,
                    {busReq, accessFault}, {1'b1, 1'(c == TO)});
            end
            tick();
        end
        tests++;
        if (stalls !== TO) begin
            fails++; $display("FAIL timeout_stalls: got %0d expected %0d", stalls, TO);
        end
        tests++;
        if ({regFileWe_MEM, loadData_MEM, instrCode_MEM} !== {1'b0, 32'h0, instr}) begin
            fails++; $display("FAIL timeout_memwb: got %b/%h/%h expected 0/0/%h",
                regFileWe_MEM, loadData_MEM, instrCode_MEM, instr);
        end
        drive_exe(1'b0, 3'b000, 1'b0, F3_W, 32'h0, 32'h0);
        #3;
        tests++;
        if ({busReq, stall_MEM, accessFault} !== 3'b000) begin
            fails++; $display("FAIL timeout_idle: got %b expected 000", {busReq, stall_MEM, accessFault});
        end
        tick();
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rdata;
        drive_exe(1'b1, RFWD_SEL_LOAD, 1'b0, F3_W, 32'h300, $urandom);
        busReady = 1'b0;
        repeat (2) tick();
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if ({busReq, stall_MEM, accessFault, busAddr, busBE} !== 39'h0) begin
            fails++; $display("FAIL rst_wait_bus: got %b/%h/%b expected 000/0/0",
                {busReq, stall_MEM, accessFault}, busAddr, busBE);
        end
        tests++;
        if ({regFileWe_MEM, instrCode_MEM, loadData_MEM, aluResult_MEM} !== 97'h0) begin
            fails++; $display("FAIL rst_wait_memwb: got %b/%h/%h/%h expected 0", regFileWe_MEM,
                instrCode_MEM, loadData_MEM, aluResult_MEM);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        rdata = $urandom;
        drive_exe(1'b1, RFWD_SEL_LOAD, 1'b0, F3_W, 32'h200, $urandom);
        busReady = 1'b1;
        busRData = rdata;
        #3;
        tests++;
        if ({busReq, stall_MEM, busAddr} !== {2'b10, 32'h200}) begin
            fails++; $display("FAIL rst_wait_next: got %b/%h expected 10/00000200", {busReq, stall_MEM}, busAddr);
        end
        tick();
        tests++;
        if ({regFileWe_MEM, loadData_MEM} !== {1'b1, rdata}) begin
            fails++; $display("FAIL rst_wait_load: got %b/%h expected 1/%h", regFileWe_MEM, loadData_MEM, rdata);
        end
    endtask

    initial begin
        reset    = 1'b1;
        busReady = 1'b0;
        busRData = '0;
        drive_exe(1'b0, 3'b000, 1'b0, F3_B, 32'h0, 32'h0);
        test_reset();
        test_alu();
        test_store();
        test_load_waits();
        test_fault();
        test_timeout();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
